communication_send: RTL and testbench

COMMUNICATION_SEND -- requirements
Module: communication_send

---
 rtl/comm_pkg.sv | 22 ++
 rtl/comm_bitclk_gen.sv | 30 +++
 rtl/communication_send.sv | 165 ++++++++++++++++
 tb/tb_communication_send.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared FSM states, frame constants and parity helper for communication_send
package comm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_ACK
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/comm_bitclk_gen.sv
// rtl/comm_bitclk_gen.sv - free-running bit clock (freq) with a one-cycle falling-edge tick
module comm_bitclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk1,
    input  logic rst_n,
    output logic freq,
    output logic fall_tick
);

    logic [7:0] div_cnt;
    logic       div_end;

    assign div_end   = (div_cnt == 8'(CLK_DIV - 1));
    // High on the cycle whose closing edge drives freq 1->0, so state moves with that edge
    assign fall_tick = freq & div_end;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            div_cnt <= '0;
            freq    <= 1'b0;
        end else if (div_end) begin
            div_cnt <= '0;
            freq    <= ~freq;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/communication_send.sv
// rtl/communication_send.sv - framed serial byte sender; COMM_SEND_ACK_WAIT_EN adds ack wait/timeout
module communication_send
    import comm_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int STOP_BITS   = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       send_req,
    output logic       ready,
    input  logic       ack,
    output logic       send_data,
    output logic       freq,
    output logic       rec_en,
    output logic       frame_done,
    output logic       ack_err
);

    logic                 fall_tick;
    state_t               state_q, state_d;
    logic                 pend_q, pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 send_d, rec_en_d, ready_d, frame_done_d;

    comm_bitclk_gen #(.CLK_DIV(CLK_DIV)) u_bitclk (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .freq      (freq),
        .fall_tick (fall_tick)
    );

`ifdef COMM_SEND_ACK_WAIT_EN
    logic [2:0] ack_sync;
    logic       ack_rise;
    logic       ack_err_d;

    assign ack_rise = ack_sync[1] & ~ack_sync[2];

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            ack_sync <= '0;
            ack_err  <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[1:0], ack};
            ack_err  <= ack_err_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ack ^ (ACK_TIMEOUT == 0);
    assign ack_err    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        data_d       = data_q;
        bit_idx_d    = bit_idx_q;
        cnt_d        = cnt_q;
        send_d       = send_data;
        rec_en_d     = rec_en;
        frame_done_d = 1'b0;
`ifdef COMM_SEND_ACK_WAIT_EN
        ack_err_d    = 1'b0;
`endif
        // ready is only ever high in IDLE with nothing pending, so this cannot overlap a frame
        if (send_req && ready) begin
            pend_d = 1'b1;
            data_d = in_data;
        end
        case (state_q)
            IDLE: if (fall_tick && pend_q) begin
                state_d  = LEAD;
                pend_d   = 1'b0;
                send_d   = STOP_BIT;
                rec_en_d = 1'b1;
            end
            LEAD: if (fall_tick) begin
                state_d = START;
                send_d  = START_BIT;
            end
            START: if (fall_tick) begin
                state_d   = DATA;
                send_d    = data_q[0];
                bit_idx_d = 3'd0;
            end
            DATA: if (fall_tick) begin
                if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                    state_d   = PARITY;
                    send_d    = even_parity(data_q);
                    bit_idx_d = 3'd0;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    send_d    = data_q[bit_idx_q + 3'd1];
                end
            end
            PARITY: if (fall_tick) begin
                state_d = STOP;
                send_d  = STOP_BIT;
                cnt_d   = '0;
            end
            STOP: if (fall_tick) begin
                if (cnt_q == 8'(STOP_BITS - 1)) begin
                    rec_en_d     = 1'b0;
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
`ifdef COMM_SEND_ACK_WAIT_EN
                    state_d      = WAIT_ACK;
`else
                    state_d      = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef COMM_SEND_ACK_WAIT_EN
            // An ack edge wins over a timeout landing in the same cycle
            WAIT_ACK: if (ack_rise) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (fall_tick) begin
                if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    ack_err_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) && !pend_d;
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            data_q     <= '0;
            bit_idx_q  <= '0;
            cnt_q      <= '0;
            send_data  <= STOP_BIT;
            rec_en     <= 1'b0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            send_data  <= send_d;
            rec_en     <= rec_en_d;
            ready      <= ready_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_communication_send.sv
// tb/tb_communication_send.sv - table-driven bench for communication_send (CLK_DIV=4, STOP_BITS=3)
module tb_communication_send;

    localparam int CLK_DIV     = 4;
    localparam int STOP_BITS   = 3;
    localparam int ACK_TIMEOUT = 2;

    logic       clk1     = 1'b0;
    logic       rst_n    = 1'b0;
    logic       send_req = 1'b0;
    logic       ack      = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       ready, send_data, freq, rec_en, frame_done, ack_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  data;
        logic        inject;
        logic [13:0] exp_line;
        int          ack_at;
    } vec_t;

    vec_t vecs[6];

    always #5 clk1 = ~clk1;

    communication_send #(
        .CLK_DIV     (CLK_DIV),
        .STOP_BITS   (STOP_BITS),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .send_req   (send_req),
        .ready      (ready),
        .ack        (ack),
        .send_data  (send_data),
        .freq       (freq),
        .rec_en     (rec_en),
        .frame_done (frame_done),
        .ack_err    (ack_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 300) begin
            @(negedge clk1);
            n++;
        end
        chk("ready_before_send", ready, 1);
    endtask

    // c counts cycles after the edge that enters LEAD; START begins at c=8
    task automatic run_frame(input vec_t v);
        int          n;
        logic [13:0] line;
        int          re_hi, re_last, fd_cnt, fd_at, err_cnt, err_at, rdy_at, unstable, freq_bad, late_re;
        logic        prev;
        wait_ready();
        in_data  = v.data;
        send_req = 1'b1;
        @(negedge clk1);
        send_req = 1'b0;
        in_data  = ~v.data;
        chk("ready_low_after_accept", ready, 0);
        n = 0;
        while (!rec_en && n < 40) begin
            @(negedge clk1);
            n++;
        end
        chk("lead_start_latency", (n <= 2 * CLK_DIV) ? 1 : 0, 1);
        line = '0; re_hi = 0; re_last = -1; fd_cnt = 0; fd_at = -1; err_cnt = 0; err_at = -1;
        rdy_at = -1; unstable = 0; freq_bad = 0;
        prev = send_data;
        for (int c = 0; c < 144; c++) begin
            if (c == v.ack_at) ack = 1'b1;
            if (v.inject && c == 30) begin
                in_data  = 8'hFF;
                send_req = 1'b1;
            end
            if (v.inject && c == 32) send_req = 1'b0;
            if (c % 8 == 4 && c < 112) line[c / 8] = send_data;
            if (c % 8 != 0 && send_data !== prev) unstable++;
            prev = send_data;
            if (freq !== (((c % 8) >= 4) ? 1'b1 : 1'b0)) freq_bad++;
            if (rec_en) begin
                re_hi++;
                re_last = c;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_at = c;
            end
            if (ack_err) begin
                err_cnt++;
                err_at = c;
            end
            if (ready && rdy_at < 0) rdy_at = c;
            @(negedge clk1);
        end
        ack = 1'b0;
        chk($sformatf("line_%02h", v.data), line, v.exp_line);
        chk("line_changes_only_on_fall", unstable, 0);
        chk("freq_phase", freq_bad, 0);
        chk("rec_en_cycles", re_hi, 112);
        chk("rec_en_periods_after_lead", (re_last + 1 - 8) / 8, 13);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_done_after_lead", fd_at - 8, 104);
`ifdef COMM_SEND_ACK_WAIT_EN
        if (v.ack_at >= 0) begin
            chk("ack_err_with_ack", err_cnt, 0);
            chk("ready_within_3_of_ack", (rdy_at > v.ack_at && rdy_at <= v.ack_at + 3) ? 1 : 0, 1);
        end else begin
            chk("ack_err_count", err_cnt, 1);
            chk("ack_err_at", err_at, 128);
            chk("ready_after_timeout", rdy_at, 128);
        end
`else
        chk("ack_err_idle", err_cnt, 0);
        chk("ready_after_frame", rdy_at, 112);
`endif
        if (v.inject) begin
            late_re = 0;
            for (int c = 0; c < 40; c++) begin
                if (rec_en) late_re++;
                @(negedge clk1);
            end
            chk("busy_request_not_queued", late_re, 0);
        end
    endtask

    initial begin
        int n, hi, lo, fd, re;
        vecs[0] = '{8'hA5, 1'b0, 14'b111_0_10100101_0_1, 122};
        vecs[1] = '{8'h07, 1'b0, 14'b111_1_00000111_0_1, -1};
        vecs[2] = '{8'h3C, 1'b1, 14'b111_0_00111100_0_1, -1};
        vecs[3] = '{8'h00, 1'b0, 14'b111_0_00000000_0_1, -1};
        vecs[4] = '{8'hFF, 1'b0, 14'b111_0_11111111_0_1, -1};
        vecs[5] = '{8'h80, 1'b0, 14'b111_1_10000000_0_1, -1};

        repeat (3) @(negedge clk1);
        chk("rst_send_data", send_data, 1);
        chk("rst_freq", freq, 0);
        chk("rst_rec_en", rec_en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ack_err", ack_err, 0);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("ready_first_edge", ready, 1);

        n = 0;
        while (!freq && n < 20) begin
            @(negedge clk1);
            n++;
        end
        hi = 0;
        while (freq && hi < 20) begin
            @(negedge clk1);
            hi++;
        end
        lo = 0;
        while (!freq && lo < 20) begin
            @(negedge clk1);
            lo++;
        end
        chk("freq_high_run", hi, CLK_DIV);
        chk("freq_low_run", lo, CLK_DIV);

        wait_ready();
        in_data  = 8'hA5;
        send_req = 1'b1;
        @(negedge clk1);
        send_req = 1'b0;
        n = 0;
        while (!rec_en && n < 40) begin
            @(negedge clk1);
            n++;
        end
        repeat (50) @(negedge clk1);
        rst_n = 1'b0;
        @(negedge clk1);
        chk("abort_send_data", send_data, 1);
        chk("abort_rec_en", rec_en, 0);
        chk("abort_freq", freq, 0);
        chk("abort_ready", ready, 0);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("abort_ready_release", ready, 1);
        fd = 0;
        re = 0;
        for (int c = 0; c < 150; c++) begin
            if (frame_done) fd++;
            if (rec_en) re++;
            @(negedge clk1);
        end
        chk("abort_no_frame_done", fd, 0);
        chk("abort_no_resend", re, 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
